// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter -- multi-cycle ALU with iterative multiply and divide
//
// Logic and add/subtract/compare operations complete in one cycle. Unsigned
// multiply (shift-add) and unsigned divide (restoring) each take one bit per
// clock for WIDTH cycles. Results are registered and change only when the
// controller enters DONE, so they stay stable between operations.
//
// Ports
//   clock2    in   1      system clock, rising edge
//   reset     in   1      asynchronous reset, active high
//   start     in   1      operation request, sampled only in IDLE
//   ULAops    in   3      opcode: AND ADD SUB OR SLT XOR MUL DIVU
//   ULAa      in   WIDTH  operand A / dividend
//   ULAb      in   WIDTH  operand B / divisor
//   ULAout    out  WIDTH  result, product low half, or quotient
//   ULAhi     out  WIDTH  product high half, remainder, else 0
//   busy      out  1      controller is not in IDLE
//   done      out  1      one-cycle pulse while results become valid
//   zero      out  1      ULAout == 0
//   overflow  out  1      signed overflow of ADD/SUB
//   div_zero  out  1      DIVU issued with ULAb == 0
// -----------------------------------------------------------------------------
module alu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clock2,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       ULAops,
   input  logic [WIDTH-1:0] ULAa,
   input  logic [WIDTH-1:0] ULAb,
   output logic [WIDTH-1:0] ULAout,
   output logic [WIDTH-1:0] ULAhi,
   output logic             busy,
   output logic             done,
   output logic             zero,
   output logic             overflow,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_OR   = 3'd3,
      OP_SLT  = 3'd4,
      OP_XOR  = 3'd5,
      OP_MUL  = 3'd6,
      OP_DIVU = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Controller and iteration state
   state_e           state_q;
   op_e              op_q;        // latched opcode (only MUL/DIVU reach CALC)
   logic [WIDTH-1:0] b_q;         // latched multiplicand / divisor
   logic [WIDTH-1:0] hi_q;        // MUL: partial product high; DIVU: remainder
   logic [WIDTH-1:0] lo_q;        // MUL: multiplier/product low; DIVU: dividend/quotient
   logic [CNT_W-1:0] cnt_q;

   // Registered outputs
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] hi_out_q;
   logic             busy_q;
   logic             done_q;
   logic             zero_q;
   logic             ovf_q;
   logic             dz_q;

   // Single-cycle datapath, evaluated on the live inputs at the start edge
   op_e              op_in;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] comb_res;
   logic             comb_ovf;

   // Iteration datapath
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] iter_hi;
   logic [WIDTH-1:0] iter_lo;

   assign op_in = op_e'(ULAops);
   assign sum   = ULAa + ULAb;
   assign diff  = ULAa - ULAb;

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the case statements can leave it unassigned and infer a latch.
   always_comb begin
      comb_res = '0;
      comb_ovf = 1'b0;
      case (op_in)
         OP_AND: comb_res = ULAa & ULAb;
         OP_OR:  comb_res = ULAa | ULAb;
         OP_XOR: comb_res = ULAa ^ ULAb;
         OP_ADD: begin
            comb_res = sum;
            comb_ovf = (ULAa[WIDTH-1] == ULAb[WIDTH-1]) && (sum[WIDTH-1] != ULAa[WIDTH-1]);
         end
         OP_SUB: begin
            comb_res = diff;
            comb_ovf = (ULAa[WIDTH-1] != ULAb[WIDTH-1]) && (diff[WIDTH-1] != ULAa[WIDTH-1]);
         end
         OP_SLT: comb_res = {{(WIDTH-1){1'b0}}, ($signed(ULAa) < $signed(ULAb))};
         default: comb_res = '0;
      endcase
   end

   // One iteration step of either algorithm. Both leave the low result word in
   // lo and the high word (product high / remainder) in hi, so the final
   // outputs are taken identically for MUL and DIVU.
   always_comb begin
      // Shift-add: add multiplicand into the high half when the multiplier LSB
      // is set, then shift the whole {carry, hi, lo} right by one.
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

      // Restoring division: shift the next dividend bit into the remainder and
      // subtract the divisor only when it fits. The remainder stays below the
      // divisor, so a WIDTH-bit subtraction is exact when it is taken.
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_q});

      iter_hi   = hi_q;
      iter_lo   = lo_q;
      if (op_q == OP_MUL) begin
         iter_hi = mul_sum[WIDTH:1];
         iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else begin
         iter_hi = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
         iter_lo = {lo_q[WIDTH-2:0], div_ge};
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock2 or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_AND;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         hi_out_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (op_in == OP_MUL || (op_in == OP_DIVU && ULAb != '0)) begin
                     state_q <= ST_CALC;
                     op_q    <= op_in;
                     b_q     <= ULAb;
                     hi_q    <= '0;
                     lo_q    <= ULAa;
                     cnt_q   <= '0;
                  end else if (op_in == OP_DIVU) begin
                     // Divide by zero: report immediately, no iterations.
                     state_q  <= ST_DONE;
                     done_q   <= 1'b1;
                     out_q    <= '1;
                     hi_out_q <= ULAa;
                     zero_q   <= 1'b0;
                     ovf_q    <= 1'b0;
                     dz_q     <= 1'b1;
                  end else begin
                     state_q  <= ST_DONE;
                     done_q   <= 1'b1;
                     out_q    <= comb_res;
                     hi_out_q <= '0;
                     zero_q   <= (comb_res == '0);
                     ovf_q    <= comb_ovf;
                     dz_q     <= 1'b0;
                  end
               end
            end

            ST_CALC: begin
               hi_q <= iter_hi;
               lo_q <= iter_lo;
               if (cnt_q == CNT_LAST) begin
                  state_q  <= ST_DONE;
                  done_q   <= 1'b1;
                  out_q    <= iter_lo;
                  hi_out_q <= iter_hi;
                  zero_q   <= (iter_lo == '0);
                  ovf_q    <= 1'b0;
                  dz_q     <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            ST_DONE: begin
               // start is ignored here; the next request must arrive in IDLE.
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ULAout   = out_q;
   assign ULAhi    = hi_out_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_alu_iter.sv
// -----------------------------------------------------------------------------
// tb_alu_iter -- directed self-checking bench for alu_iter (WIDTH = 32)
//
// Inputs change on the falling clock edge and outputs are sampled on the
// falling edge, half a cycle away from the rising edge the DUT uses.
// -----------------------------------------------------------------------------
module tb_alu_iter;

   localparam int W = 32;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_SLT  = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_MUL  = 3'd6;
   localparam logic [2:0] OP_DIVU = 3'd7;

   logic         clock2;
   logic         reset;
   logic         start;
   logic [2:0]   ULAops;
   logic [W-1:0] ULAa;
   logic [W-1:0] ULAb;
   logic [W-1:0] ULAout;
   logic [W-1:0] ULAhi;
   logic         busy;
   logic         done;
   logic         zero;
   logic         overflow;
   logic         div_zero;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;
   int n_done;

   alu_iter #(.WIDTH(W)) dut (
      .clock2   (clock2),
      .reset    (reset),
      .start    (start),
      .ULAops   (ULAops),
      .ULAa     (ULAa),
      .ULAb     (ULAb),
      .ULAout   (ULAout),
      .ULAhi    (ULAhi),
      .busy     (busy),
      .done     (done),
      .zero     (zero),
      .overflow (overflow),
      .div_zero (div_zero)
   );

   initial clock2 = 1'b0;
   always #5 clock2 = ~clock2;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation and wait (bounded) for done; lat counts falling
   // edges from the start edge to the first one that sees done high.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int l);
      @(negedge clock2);
      ULAops = op;
      ULAa   = a;
      ULAb   = b;
      start  = 1'b1;
      @(negedge clock2);
      start = 1'b0;
      l = 1;
      while (done !== 1'b1 && l < 100) begin
         @(negedge clock2);
         l++;
      end
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      ULAops = OP_AND;
      ULAa   = '0;
      ULAb   = '0;

      // ---------------- reset state ----------------
      repeat (3) @(negedge clock2);
      check("rst_out",  ULAout, 32'd0);
      check("rst_hi",   ULAhi, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_ovf",  32'(overflow), 32'd0);
      check("rst_dz",   32'(div_zero), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clock2);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);

      // ---------------- ADD 3000+2000 ----------------
      check("add_busy_before", 32'(busy), 32'd0);
      run_op(OP_ADD, 32'd3000, 32'd2000, lat);
      check("add_lat",  32'(lat), 32'd1);
      check("add_out",  ULAout, 32'd5000);
      check("add_hi",   ULAhi, 32'd0);
      check("add_zero", 32'(zero), 32'd0);
      check("add_ovf",  32'(overflow), 32'd0);
      check("add_busy", 32'(busy), 32'd1);
      @(negedge clock2);
      check("add_busy_after", 32'(busy), 32'd0);
      check("add_done_pulse", 32'(done), 32'd0);
      check("add_hold", ULAout, 32'd5000);

      // ---------------- SUB ----------------
      run_op(OP_SUB, 32'd4000, 32'd2000, lat);
      check("sub_lat", 32'(lat), 32'd1);
      check("sub_out", ULAout, 32'd2000);
      run_op(OP_SUB, 32'd2000, 32'd2000, lat);
      check("sub0_out",  ULAout, 32'd0);
      check("sub0_zero", 32'(zero), 32'd1);
      run_op(OP_SUB, 32'h8000_0000, 32'd1, lat);
      check("subovf_out", ULAout, 32'h7FFF_FFFF);
      check("subovf_ovf", 32'(overflow), 32'd1);

      // ---------------- ADD overflow ----------------
      run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, lat);
      check("addovf_out", ULAout, 32'h8000_0000);
      check("addovf_ovf", 32'(overflow), 32'd1);
      check("addovf_zero", 32'(zero), 32'd0);

      // ---------------- logic ops ----------------
      run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
      check("and_out", ULAout, 32'h00F0_1200);
      check("and_ovf", 32'(overflow), 32'd0);
      run_op(OP_OR, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
      check("or_out", ULAout, 32'hFFF0_FF34);
      run_op(OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
      check("xor_out", ULAout, 32'hFF00_ED34);

      // ---------------- SLT (signed) ----------------
      run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, lat);
      check("slt_neg_out", ULAout, 32'd1);
      run_op(OP_SLT, 32'd1, 32'hFFFF_FFFF, lat);
      check("slt_pos_out",  ULAout, 32'd0);
      check("slt_pos_zero", 32'(zero), 32'd1);
      run_op(OP_SLT, 32'd5, 32'd3, lat);
      check("slt_gt_out", ULAout, 32'd0);

      // ---------------- ADD to set a known previous result ----------------
      run_op(OP_ADD, 32'd11, 32'd22, lat);
      check("prev_out", ULAout, 32'd33);

      // ---------------- MUL with ignored start and operand changes ----------------
      @(negedge clock2);
      ULAops = OP_MUL;
      ULAa   = 32'd3000;
      ULAb   = 32'd2000;
      start  = 1'b1;
      @(negedge clock2);
      start = 1'b0;
      lat   = 1;
      repeat (4) begin
         @(negedge clock2);
         lat++;
      end
      ULAops = OP_ADD;
      ULAa   = 32'd1;
      ULAb   = 32'd1;
      start  = 1'b1;
      check("mul_calc_busy", 32'(busy), 32'd1);
      check("mul_calc_hold_out", ULAout, 32'd33);
      check("mul_calc_hold_done", 32'(done), 32'd0);
      @(negedge clock2);
      lat++;
      start = 1'b0;
      ULAa  = 32'h55;
      ULAb  = 32'h66;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clock2);
         lat++;
      end
      check("mul_lat", 32'(lat), 32'd33);
      check("mul_out", ULAout, 32'd6000000);
      check("mul_hi",  ULAhi, 32'd0);
      check("mul_zero", 32'(zero), 32'd0);
      n_done = 0;
      repeat (4) begin
         @(negedge clock2);
         if (done === 1'b1) n_done++;
      end
      check("mul_no_queued_add", 32'(n_done), 32'd0);
      check("mul_result_kept", ULAout, 32'd6000000);

      // ---------------- MUL extremes ----------------
      run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      check("mulmax_lat", 32'(lat), 32'd33);
      check("mulmax_out", ULAout, 32'h0000_0001);
      check("mulmax_hi",  ULAhi, 32'hFFFF_FFFE);
      run_op(OP_MUL, 32'h0001_0003, 32'h0002_0005, lat);
      check("mulmix_out", ULAout, 32'h000B_000F);
      check("mulmix_hi",  ULAhi, 32'h0000_0002);

      // ---------------- DIVU ----------------
      run_op(OP_DIVU, 32'd4000, 32'd2000, lat);
      check("div_lat", 32'(lat), 32'd33);
      check("div_out", ULAout, 32'd2);
      check("div_hi",  ULAhi, 32'd0);
      check("div_dz",  32'(div_zero), 32'd0);
      run_op(OP_DIVU, 32'd100, 32'd7, lat);
      check("div7_out", ULAout, 32'd14);
      check("div7_hi",  ULAhi, 32'd2);
      run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, lat);
      check("divbig_out", ULAout, 32'h0000_FFFF);
      check("divbig_hi",  ULAhi, 32'h0000_FFFF);
      run_op(OP_DIVU, 32'd7, 32'd0, lat);
      check("div0_lat",  32'(lat), 32'd1);
      check("div0_out",  ULAout, 32'hFFFF_FFFF);
      check("div0_hi",   ULAhi, 32'd7);
      check("div0_dz",   32'(div_zero), 32'd1);
      check("div0_zero", 32'(zero), 32'd0);
      run_op(OP_ADD, 32'd1, 32'd2, lat);
      check("dz_cleared", 32'(div_zero), 32'd0);

      // ---------------- back-to-back: start held high ----------------
      @(negedge clock2);
      ULAops = OP_ADD;
      ULAa   = 32'd40;
      ULAb   = 32'd2;
      start  = 1'b1;
      n_done = 0;
      repeat (4) begin
         @(negedge clock2);
         if (done === 1'b1) n_done++;
      end
      start = 1'b0;
      repeat (3) begin
         @(negedge clock2);
         if (done === 1'b1) n_done++;
      end
      check("b2b_done_count", 32'(n_done), 32'd2);
      check("b2b_out", ULAout, 32'd42);

      // ---------------- reset during MUL ----------------
      run_op(OP_ADD, 32'd5, 32'd6, lat);
      @(negedge clock2);
      ULAops = OP_MUL;
      ULAa   = 32'd123;
      ULAb   = 32'd456;
      start  = 1'b1;
      @(negedge clock2);
      start = 1'b0;
      repeat (9) @(negedge clock2);
      reset = 1'b1;
      #1;
      check("abort_out",  ULAout, 32'd0);
      check("abort_hi",   ULAhi, 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_zero", 32'(zero), 32'd0);
      check("abort_ovf",  32'(overflow), 32'd0);
      check("abort_dz",   32'(div_zero), 32'd0);
      repeat (2) @(negedge clock2);
      reset  = 1'b0;
      n_done = 0;
      repeat (40) begin
         @(negedge clock2);
         if (done === 1'b1 || busy === 1'b1) n_done++;
      end
      check("abort_no_done", 32'(n_done), 32'd0);
      check("abort_out_quiet", ULAout, 32'd0);
      run_op(OP_ADD, 32'd10, 32'd20, lat);
      check("after_rst_lat", 32'(lat), 32'd1);
      check("after_rst_out", ULAout, 32'd30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, the operand and result width in bits (legal range 4..64).
REQ-002 clock2  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 ULAops  input  3  opcode: 0 AND, 1 ADD, 2 SUB, 3 OR, 4 SLT (signed), 5 XOR, 6 MUL (unsigned), 7 DIVU.
REQ-006 ULAa  input  WIDTH  operand A (dividend for DIVU).
REQ-007 ULAb  input  WIDTH  operand B (divisor for DIVU).
REQ-008 ULAout  output  WIDTH  result: logic/arith result, product low half, or quotient.
REQ-009 ULAhi  output  WIDTH  product high half (MUL), remainder (DIVU), 0 otherwise.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse marking valid results.
REQ-012 zero  output  1  ULAout equals 0.
REQ-013 overflow  output  1  signed overflow of ADD/SUB; 0 for other ops.
REQ-014 div_zero  output  1  DIVU issued with ULAb = 0.

Function
REQ-015 FSM states SHALL be IDLE, CALC, DONE; IDLE is the reset state.
REQ-016 In IDLE with start=1, ULAops, ULAa and ULAb SHALL be latched; later input changes SHALL not affect that operation.
REQ-017 Ops 0-5 SHALL go IDLE -> DONE, so done is high on the first edge after the start edge (latency 1).
REQ-018 MUL SHALL use iterative shift-add, one bit per cycle; IDLE -> CALC for exactly WIDTH cycles -> DONE (done at start edge + WIDTH + 1).
REQ-019 DIVU SHALL use iterative restoring division, one quotient bit per cycle; same WIDTH-cycle CALC timing as MUL.
REQ-020 DIVU with ULAb = 0 SHALL skip CALC (latency 1) and give ULAout all ones, ULAhi = ULAa, div_zero = 1.
REQ-021 DONE SHALL always go to IDLE on the next edge; done is high only in DONE.
REQ-022 start while busy=1 SHALL be ignored, with no queuing; start in DONE is also ignored.
REQ-023 Back-to-back single-cycle ops SHALL sustain one result every 2 cycles.
REQ-024 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow = operand signs equal (ADD) or different (SUB) and result sign differs from ULAa's.
REQ-025 SLT SHALL give ULAout = 1 if signed ULAa < signed ULAb, else 0.
REQ-026 MUL SHALL give the exact 2*WIDTH-bit unsigned product: low half on ULAout, high half on ULAhi.
REQ-027 ULAout, ULAhi, zero, overflow and div_zero SHALL update only when entering DONE and hold until the next DONE.
REQ-028 During CALC these outputs SHALL hold the previous operation's values.

Reset
REQ-029 While reset=1: state IDLE; ULAout, ULAhi, busy, done, zero, overflow, div_zero all 0; internal iteration counters and accumulators cleared.
REQ-030 Reset during CALC SHALL abort the operation immediately with no done pulse; the first start after reset releases SHALL be accepted normally.
REQ-031 Deasserting reset SHALL not produce done, busy or any output change until a start is accepted.

Verification (WIDTH=32)
REQ-032 ADD 3000+2000, start one cycle -> done 1 cycle later, ULAout=5000, zero=0, overflow=0, busy high for exactly 1 cycle.
REQ-033 SUB 4000-2000 -> ULAout=2000; SUB 2000-2000 -> ULAout=0, zero=1; ADD 0x7FFFFFFF+1 -> ULAout=0x80000000, overflow=1.
REQ-034 MUL 3000*2000 -> done exactly 33 cycles after start edge, ULAout=6000000, ULAhi=0; MUL 0xFFFFFFFF*0xFFFFFFFF -> ULAhi=0xFFFFFFFE, ULAout=0x00000001.
REQ-035 DIVU 4000/2000 -> ULAout=2, ULAhi=0 after 33 cycles; DIVU 7/0 -> done after 1 cycle, ULAout=0xFFFFFFFF, ULAhi=7, div_zero=1.
REQ-036 Start MUL, pulse start with ADD at cycle 5 and change operands mid-CALC -> ADD ignored, MUL result unaffected.
REQ-037 Assert reset at cycle 10 of a MUL -> all outputs 0, no done pulse; an ADD issued after reset gives the correct result.
